// File: rtl/apb4_mem_slave.sv
// APB4 completer around a DEPTH x D_WIDTH register-file memory with byte strobes,
// PSLVERR on out-of-range words and abort on protocol violation. Wait states via `APB_WAIT_EN.
module apb4_mem_slave #(
  parameter int                 A_WIDTH     = 8,
  parameter int                 D_WIDTH     = 32,
  parameter int                 DEPTH       = 16,
  parameter int                 WAIT_CYCLES = 2,
  parameter logic [D_WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                   p_clk,
  input  logic                   p_rst,
  input  logic                   p_sel,
  input  logic                   p_enable,
  input  logic                   p_write,
  input  logic [A_WIDTH-1:0]     p_addr,
  input  logic [D_WIDTH-1:0]     wr_data,
  input  logic [D_WIDTH/8-1:0]   p_strb,
  output logic [D_WIDTH-1:0]     rd_data,
  output logic                   p_ready,
  output logic                   p_slverr
);

  localparam int NB    = D_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [0:0] {IDLE, ACCESS} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 wr_q, wr_d;
  logic                 err_q, err_d;
  logic [D_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]        strb_q, strb_d;
  logic [D_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [D_WIDTH-1:0]   mem_q [DEPTH];
  logic [D_WIDTH-1:0]   mem_d [DEPTH];

  logic setup;
  logic access_ok;
  logic in_range;
  logic cnt_zero;

  assign setup     = (state_q == IDLE) && p_sel && !p_enable;
  assign access_ok = p_sel && p_enable;
  assign in_range  = ({1'b0, p_addr} < (A_WIDTH + 1)'(DEPTH));

`ifdef APB_WAIT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (setup) begin
      cnt_d = CNT_W'(WAIT_CYCLES);
    end else if (state_q == ACCESS) begin
      if (!access_ok)
        cnt_d = '0;
      else if (cnt_q != '0)
        cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge p_clk) begin
    if (p_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_zero = (cnt_q == '0);
`else
  // No counter: the access phase always completes in its first cycle.
  logic [CNT_W-1:0] cnt_tie;
  assign cnt_tie  = '0;
  assign cnt_zero = (cnt_tie == '0);
`endif

  // Ready/error are pure decodes of registered state, so no input reaches them combinationally.
  assign p_ready  = (state_q == ACCESS) && cnt_zero;
  assign p_slverr = p_ready && err_q;
  assign rd_data  = rd_data_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    rd_data_d = rd_data_q;
    mem_d     = mem_q;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          idx_d   = p_addr[IDX_W-1:0];
          wr_d    = p_write;
          err_d   = !in_range;
          wdata_d = wr_data;
          strb_d  = p_strb;
          state_d = ACCESS;
          if (!p_write)
            rd_data_d = in_range ? mem_q[p_addr[IDX_W-1:0]] : '0;
        end
      end
      ACCESS: begin
        if (!access_ok) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          state_d = IDLE;
          if (wr_q && !err_q) begin
            for (int i = 0; i < NB; i++)
              if (strb_q[i]) mem_d[idx_q][8*i +: 8] = wdata_q[8*i +: 8];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge p_clk) begin
    if (p_rst) begin
      state_q   <= IDLE;
      rd_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
    end else begin
      state_q   <= state_d;
      rd_data_q <= rd_data_d;
      mem_q     <= mem_d;
    end
  end

  // Transfer attributes are only consumed in ACCESS, so they need no reset.
  always_ff @(posedge p_clk) begin
    idx_q   <= idx_d;
    wr_q    <= wr_d;
    err_q   <= err_d;
    wdata_q <= wdata_d;
    strb_q  <= strb_d;
  end

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Directed self-checking bench for apb4_mem_slave; adapts expected wait states to `APB_WAIT_EN.
module tb_apb4_mem_slave;

`ifdef APB_WAIT_EN
  localparam int WAITS = 2;
`else
  localparam int WAITS = 0;
`endif
  localparam logic [31:0] RV = 32'hA5A5A5A5;

  logic        p_clk;
  logic        p_rst;
  logic        p_sel;
  logic        p_enable;
  logic        p_write;
  logic [7:0]  p_addr;
  logic [31:0] wr_data;
  logic [3:0]  p_strb;
  logic [31:0] rd_data;
  logic        p_ready;
  logic        p_slverr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  apb4_mem_slave #(
    .A_WIDTH(8), .D_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(2), .RESET_VAL(RV)
  ) dut (
    .p_clk(p_clk), .p_rst(p_rst), .p_sel(p_sel), .p_enable(p_enable),
    .p_write(p_write), .p_addr(p_addr), .wr_data(wr_data), .p_strb(p_strb),
    .rd_data(rd_data), .p_ready(p_ready), .p_slverr(p_slverr)
  );

  initial p_clk = 1'b0;
  always #5 p_clk = ~p_clk;
  always @(posedge p_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // One APB transfer; returns at the falling edge of the completing cycle (or after a bound).
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, output logic [31:0] rd, output logic err,
                      output int waits);
    int n;
    @(posedge p_clk); #1;
    p_sel = 1'b1; p_enable = 1'b0; p_write = wr; p_addr = addr; wr_data = data; p_strb = strb;
    @(posedge p_clk); #1;
    p_enable = 1'b1;
    @(negedge p_clk);
    n = 0;
    while (!p_ready && n < 20) begin
      n++;
      @(negedge p_clk);
    end
    rd    = rd_data;
    err   = p_slverr;
    waits = p_ready ? n : -1;
  endtask

  task automatic bus_idle();
    @(posedge p_clk); #1;
    p_sel = 1'b0; p_enable = 1'b0; p_write = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int w;
    p_rst = 1'b1;
    repeat (2) @(posedge p_clk);
    #1 p_rst = 1'b0;
    @(negedge p_clk);
    checks++; if (p_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", p_ready); end
    checks++; if (p_slverr !== 1'b0) begin errors++; $display("FAIL reset_slverr: got %b expected 0", p_slverr); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 00000000", rd_data); end
    xfer(1'b0, 8'd3, 32'h0, 4'h0, rd, er, w);
    checks++; if (rd !== RV) begin errors++; $display("FAIL reset_mem_read3: got %h expected %h", rd, RV); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL reset_read3_slverr: got %b expected 0", er); end
    checks++; if (w !== WAITS) begin errors++; $display("FAIL reset_read3_waits: got %0d expected %0d", w, WAITS); end
    bus_idle();
  endtask

  task automatic test_strobed_write();
    logic [31:0] rd; logic er; int w;
    xfer(1'b1, 8'd5, 32'h11223344, 4'b1111, rd, er, w);
    checks++; if (er !== 1'b0 || w !== WAITS) begin errors++; $display("FAIL strb_full_write: got err=%b waits=%0d expected err=0 waits=%0d", er, w, WAITS); end
    xfer(1'b1, 8'd5, 32'hAABBCCDD, 4'b0101, rd, er, w);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL strb_partial_write_err: got %b expected 0", er); end
    xfer(1'b0, 8'd5, 32'h0, 4'h0, rd, er, w);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strb_read5: got %h expected 11bb33dd", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL strb_read5_slverr: got %b expected 0", er); end
    xfer(1'b1, 8'd5, 32'hFFFFFFFF, 4'b0000, rd, er, w);
    checks++; if (er !== 1'b0 || w !== WAITS) begin errors++; $display("FAIL strb_zero_write: got err=%b waits=%0d expected err=0 waits=%0d", er, w, WAITS); end
    xfer(1'b0, 8'd5, 32'h0, 4'h0, rd, er, w);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strb_zero_noop: got %h expected 11bb33dd", rd); end
    xfer(1'b1, 8'd15, 32'hDEADBEEF, 4'b1111, rd, er, w);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL last_word_write_err: got %b expected 0", er); end
    xfer(1'b0, 8'd15, 32'h0, 4'h0, rd, er, w);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL last_word_read: got %h expected deadbeef", rd); end
    xfer(1'b1, 8'd14, 32'hCAFEF00D, 4'b1010, rd, er, w);
    xfer(1'b0, 8'd14, 32'h0, 4'h0, rd, er, w);
    checks++; if (rd !== 32'hCAA5F0A5) begin errors++; $display("FAIL strb_upper_lanes: got %h expected caa5f0a5", rd); end
    bus_idle();
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int w; int c1; int c3;
    @(posedge p_clk); #1;
    p_sel = 1'b1; p_enable = 1'b0; p_write = 1'b0; p_addr = 8'd5; p_strb = 4'h0;
    @(negedge p_clk);
    checks++; if (p_ready !== 1'b0) begin errors++; $display("FAIL wait_setup_ready: got %b expected 0", p_ready); end
    @(posedge p_clk); #1;
    p_enable = 1'b1;
    @(negedge p_clk);
    checks++; if (rd_data !== 32'h11BB33DD) begin errors++; $display("FAIL wait_rd_data_early: got %h expected 11bb33dd", rd_data); end
    for (int k = 0; k < WAITS; k++) begin
      checks++; if (p_ready !== 1'b0) begin errors++; $display("FAIL wait_cycle_ready: cycle %0d got %b expected 0", k, p_ready); end
      @(negedge p_clk);
    end
    checks++; if (p_ready !== 1'b1 || p_slverr !== 1'b0) begin errors++; $display("FAIL wait_complete: got ready=%b slverr=%b expected ready=1 slverr=0", p_ready, p_slverr); end
    bus_idle();
    @(negedge p_clk);
    checks++; if (p_ready !== 1'b0) begin errors++; $display("FAIL wait_ready_pulse: got %b expected 0", p_ready); end
    xfer(1'b1, 8'd8, 32'h01020304, 4'hF, rd, er, w);
    c1 = cyc;
    xfer(1'b1, 8'd9, 32'h05060708, 4'hF, rd, er, w);
    xfer(1'b1, 8'd9, 32'h0A0B0C0D, 4'b0011, rd, er, w);
    c3 = cyc;
    checks++; if (c3 - c1 !== 2 * (2 + WAITS)) begin errors++; $display("FAIL back_to_back_cycles: got %0d expected %0d", c3 - c1, 2 * (2 + WAITS)); end
    xfer(1'b0, 8'd9, 32'h0, 4'h0, rd, er, w);
    checks++; if (rd !== 32'h05060C0D) begin errors++; $display("FAIL back_to_back_data: got %h expected 05060c0d", rd); end
    bus_idle();
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er; int w;
    xfer(1'b1, 8'd16, 32'h12345678, 4'hF, rd, er, w);
    checks++; if (er !== 1'b1 || w !== WAITS) begin errors++; $display("FAIL oor_write: got err=%b waits=%0d expected err=1 waits=%0d", er, w, WAITS); end
    xfer(1'b0, 8'd0, 32'h0, 4'h0, rd, er, w);
    checks++; if (rd !== RV || er !== 1'b0) begin errors++; $display("FAIL oor_word0_intact: got %h err=%b expected %h err=0", rd, er, RV); end
    xfer(1'b0, 8'd15, 32'h0, 4'h0, rd, er, w);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL oor_word15_intact: got %h expected deadbeef", rd); end
    xfer(1'b0, 8'd20, 32'h0, 4'h0, rd, er, w);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_read_data: got %h expected 00000000", rd); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_read_slverr: got %b expected 1", er); end
    bus_idle();
    @(negedge p_clk);
    checks++; if (p_slverr !== 1'b0) begin errors++; $display("FAIL oor_slverr_pulse: got %b expected 0", p_slverr); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic er; int w;
    xfer(1'b0, 8'd14, 32'h0, 4'h0, rd, er, w);
    @(posedge p_clk); #1;
    p_sel = 1'b1; p_enable = 1'b0; p_write = 1'b1; p_addr = 8'd2; wr_data = 32'h0BADF00D; p_strb = 4'hF;
    @(posedge p_clk); #1;
    p_enable = 1'b1;
    p_sel    = 1'b0;
    @(posedge p_clk); #1;
    p_enable = 1'b0;
    for (int k = 0; k <= WAITS; k++) begin
      @(negedge p_clk);
      checks++; if (p_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: cycle %0d got %b expected 0", k, p_ready); end
    end
    checks++; if (rd_data !== 32'hCAA5F0A5) begin errors++; $display("FAIL abort_rd_hold: got %h expected caa5f0a5", rd_data); end
    xfer(1'b0, 8'd2, 32'h0, 4'h0, rd, er, w);
    checks++; if (rd !== RV) begin errors++; $display("FAIL abort_no_write: got %h expected %h", rd, RV); end
    xfer(1'b1, 8'd2, 32'h13579BDF, 4'hF, rd, er, w);
    checks++; if (er !== 1'b0 || w !== WAITS) begin errors++; $display("FAIL abort_next_write: got err=%b waits=%0d expected err=0 waits=%0d", er, w, WAITS); end
    xfer(1'b0, 8'd2, 32'h0, 4'h0, rd, er, w);
    checks++; if (rd !== 32'h13579BDF) begin errors++; $display("FAIL abort_next_read: got %h expected 13579bdf", rd); end
    bus_idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int w;
    @(posedge p_clk); #1;
    p_sel = 1'b1; p_enable = 1'b0; p_write = 1'b1; p_addr = 8'd7; wr_data = 32'h77777777; p_strb = 4'hF;
    @(posedge p_clk); #1;
    p_enable = 1'b1;
    p_rst    = 1'b1;
    @(posedge p_clk); #1;
    p_rst = 1'b0; p_sel = 1'b0; p_enable = 1'b0; p_write = 1'b0;
    @(negedge p_clk);
    checks++; if (p_ready !== 1'b0 || p_slverr !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got ready=%b slverr=%b expected 0 0", p_ready, p_slverr); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL midrst_rd_data: got %h expected 00000000", rd_data); end
    xfer(1'b0, 8'd7, 32'h0, 4'h0, rd, er, w);
    checks++; if (rd !== RV) begin errors++; $display("FAIL midrst_word7: got %h expected %h", rd, RV); end
    checks++; if (w !== WAITS) begin errors++; $display("FAIL midrst_idle_next: got waits=%0d expected %0d", w, WAITS); end
    xfer(1'b0, 8'd2, 32'h0, 4'h0, rd, er, w);
    checks++; if (rd !== RV) begin errors++; $display("FAIL midrst_word2_reset: got %h expected %h", rd, RV); end
    bus_idle();
  endtask

  initial begin
    p_rst = 1'b1; p_sel = 1'b0; p_enable = 1'b0; p_write = 1'b0;
    p_addr = '0; wr_data = '0; p_strb = '0;
    test_reset();
    test_strobed_write();
    test_wait_states();
    test_out_of_range();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
